// File: rtl/regfile_pkg.sv
// Shared constants, write-port record and helpers for the integer register file.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_NRD_DEF   = 2;

    // Number of write ports; port index order is priority order (highest index wins).
    localparam int RF_NWP       = 2;

    // The write-port record is sized for the widest supported configuration
    // (XLEN <= 64, NREGS <= 256); narrower instances use the low bits only.
    localparam int RF_AW_MAX    = 8;
    localparam int RF_XLEN_MAX  = 64;

    typedef struct packed {
        logic                   we;
        logic [RF_AW_MAX-1:0]   wa;
        logic [RF_XLEN_MAX-1:0] wd;
    } wr_port_t;

    // Address width for a given register count.
    function automatic int rf_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: per-register pending bit with write/flush/issue priority and a registered busy count.
// Latency: busy and busy_cnt update 1 cycle after the qualifying write/flush/issue.
// Backpressure: none; every enable is a single-cycle qualifier.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS    = RF_NREGS_DEF,
    parameter  int NWP      = RF_NWP,
    parameter  int ZERO_REG = 1,
    localparam int AW       = rf_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWP-1:0]    wr_en_i,
    input  logic [NWP*AW-1:0] wr_addr_i,
    input  logic              issue_en_i,
    input  logic [AW-1:0]     issue_rd_i,
    input  logic              flush_i,
    output logic [NREGS-1:0]  busy_o,
    output logic [AW:0]       busy_cnt_o
);

    localparam int CW = AW + 1;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Next busy vector: writebacks clear, flush clears all, issue sets last so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWP; k++) begin
            if (wr_en_i[k]) begin
                busy_d[wr_addr_i[k*AW +: AW]] = 1'b0;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
        if (issue_en_i && !(ZERO_REG != 0 && issue_rd_i == '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
    end

    // Population count of the next-state vector so busy_cnt tracks busy in the same cycle.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

    // Scoreboard state; reset drops any issue or write presented in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with write-to-read bypass, hardwired zero register and busy scoreboard.
// Latency: reads combinational (0 cycles); writes and busy updates land 1 cycle later, bypassed to reads.
// Backpressure: none; enables are single-cycle qualifiers and are always accepted.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = RF_XLEN_DEF,
    parameter  int NREGS    = RF_NREGS_DEF,
    parameter  int NRD      = RF_NRD_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra_i,
    output logic [NRD*XLEN-1:0] rd_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                we0_i,
    input  logic [AW-1:0]       wa0_i,
    input  logic [XLEN-1:0]     wd0_i,
    input  logic                we1_i,
    input  logic [AW-1:0]       wa1_i,
    input  logic [XLEN-1:0]     wd1_i,
    input  logic                issue_en_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic                flush_i,
    output logic [AW:0]         busy_cnt_o
);

    logic [XLEN-1:0]      mem_q [NREGS];
    wr_port_t             wp [RF_NWP];
    logic [RF_NWP-1:0]    wr_en;
    logic [RF_NWP*AW-1:0] wr_addr;
    logic [NREGS-1:0]     busy;
    logic [NRD-1:0]       wr_hit;
    logic                 wp_unused;

    // Gather the discrete write ports into the priority-ordered record array (port 1 last = wins).
    always_comb begin
        for (int k = 0; k < RF_NWP; k++) begin
            wp[k] = '0;
        end
        wp[0].we            = we0_i;
        wp[0].wa[AW-1:0]    = wa0_i;
        wp[0].wd[XLEN-1:0]  = wd0_i;
        wp[1].we            = we1_i;
        wp[1].wa[AW-1:0]    = wa1_i;
        wp[1].wd[XLEN-1:0]  = wd1_i;
    end

    // Flatten enables/addresses for the scoreboard; the record's spare high bits fold into a sink.
    always_comb begin
        wp_unused = 1'b0;
        for (int k = 0; k < RF_NWP; k++) begin
            wr_en[k]                = wp[k].we;
            wr_addr[k*AW +: AW]     = wp[k].wa[AW-1:0];
            wp_unused               = wp_unused ^ (^wp[k]);
        end
    end

    // Data array: later ports override earlier ones at the same address; register 0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int k = 0; k < RF_NWP; k++) begin
                if (wp[k].we && !(ZERO_REG != 0 && wp[k].wa[AW-1:0] == '0)) begin
                    mem_q[wp[k].wa[AW-1:0]] <= wp[k].wd[XLEN-1:0];
                end
            end
        end
    end

    // Per read port: does any enabled write target this address this cycle.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            wr_hit[i] = 1'b0;
            for (int k = 0; k < RF_NWP; k++) begin
                if (wp[k].we && wp[k].wa[AW-1:0] == ra_i[i*AW +: AW]) begin
                    wr_hit[i] = 1'b1;
                end
            end
        end
    end

    // Read mux: zero register, then bypass from the highest-priority matching write, then the array.
    always_comb begin
        rd_o      = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_o[i*XLEN +: XLEN] = mem_q[ra_i[i*AW +: AW]];
            for (int k = 0; k < RF_NWP; k++) begin
                if (wp[k].we && wp[k].wa[AW-1:0] == ra_i[i*AW +: AW]) begin
                    rd_o[i*XLEN +: XLEN] = wp[k].wd[XLEN-1:0];
                end
            end
            // A write landing this cycle satisfies the pending operand along with its bypassed data.
            rd_busy_o[i] = busy[ra_i[i*AW +: AW]] & ~wr_hit[i];
            if (ZERO_REG != 0 && ra_i[i*AW +: AW] == '0) begin
                rd_o[i*XLEN +: XLEN] = '0;
                rd_busy_o[i]         = 1'b0;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWP      (RF_NWP),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .issue_en_i (issue_en_i),
        .issue_rd_i (issue_rd_i),
        .flush_i    (flush_i),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt_o)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, reset corner sequence and randomized model comparison.
// Latency: reads compared before the edge, busy count after it.
// Backpressure: n/a.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  ra_i;
    logic [63:0] rd_o;
    logic [1:0]  rd_busy_o;
    logic        we0_i, we1_i, issue_en_i, flush_i;
    logic [4:0]  wa0_i, wa1_i, issue_rd_i;
    logic [31:0] wd0_i, wd1_i;
    logic [5:0]  busy_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural values and pending flags.
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .ra_i       (ra_i),
        .rd_o       (rd_o),
        .rd_busy_o  (rd_busy_o),
        .we0_i      (we0_i),
        .wa0_i      (wa0_i),
        .wd0_i      (wd0_i),
        .we1_i      (we1_i),
        .wa1_i      (wa1_i),
        .wd1_i      (wd1_i),
        .issue_en_i (issue_en_i),
        .issue_rd_i (issue_rd_i),
        .flush_i    (flush_i),
        .busy_cnt_o (busy_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we0; logic [4:0] wa0; logic [31:0] wd0;
        logic        we1; logic [4:0] wa1; logic [31:0] wd1;
        logic        iss; logic [4:0] ird; logic        fl;
        logic [4:0]  r0;  logic [4:0] r1;
        logic [31:0] e0;  logic [31:0] e1;
        logic        eb0; logic        eb1;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic iss, input logic [4:0] ird, input logic fl,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic eb0, input logic eb1, input logic [5:0] ecnt);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.iss = iss; v.ird = ird; v.fl = fl;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
        v.eb0 = eb0; v.eb1 = eb1; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        we0_i = 0; wa0_i = 0; wd0_i = 0;
        we1_i = 0; wa1_i = 0; wd1_i = 0;
        issue_en_i = 0; issue_rd_i = 0; flush_i = 0;
    endtask

    // Expected read value from the architectural view plus same-cycle writes.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0)                  return 32'h0;
        if (we1_i && wa1_i == a)     return wd1_i;
        if (we0_i && wa0_i == a)     return wd0_i;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !((we0_i && wa0_i == a) || (we1_i && wa1_i == a));
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Apply one clock edge's worth of effects to the reference state.
    task automatic model_edge();
        if (we0_i && wa0_i != 0) m_reg[wa0_i] = wd0_i;
        if (we1_i && wa1_i != 0) m_reg[wa1_i] = wd1_i;
        if (we0_i) m_busy[wa0_i] = 0;
        if (we1_i) m_busy[wa1_i] = 0;
        if (flush_i) for (int r = 0; r < 32; r++) m_busy[r] = 0;
        if (issue_en_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = 0;
            m_busy[r] = 0;
        end
    endtask

    initial begin
        rst = 1'b0;
        ra_i = '0;
        idle_inputs();
        model_reset();

        // Directed sequence; state carries from one row to the next.
        //          we0 wa0 wd0            we1 wa1 wd1     iss ird fl  r0  r1  e0             e1             b0 b1 cnt
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  1, 31, 0,            0,             0, 0, 0));
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0,  5,  0, 32'hDEADBEEF, 0,             0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF,  0, 0, 0));
        vecs.push_back(mk(1, 7, 32'h11,       1, 7, 32'h22,   0, 0, 0,  5,  7, 32'hDEADBEEF, 32'h22,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  7,  7, 32'h22,       32'h22,        0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h1234,     0, 0, 0,        0, 0, 0,  0,  0, 0,            0,             0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 0, 0,  0,  5, 0,            32'hDEADBEEF,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 3, 0,  3,  4, 0,            0,             0, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  3,  0, 0,            0,             1, 0, 1));
        vecs.push_back(mk(1, 3, 32'hABC,      0, 0, 0,        0, 0, 0,  3,  0, 32'hABC,      0,             0, 0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 3, 0,  3,  0, 32'hABC,      0,             0, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 4, 0,  3,  4, 32'hABC,      0,             1, 0, 2));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 4, 1,  3,  4, 32'hABC,      0,             1, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  3,  4, 32'hABC,      0,             0, 1, 1));
        vecs.push_back(mk(0, 0, 0,            1, 4, 32'h55,   1, 4, 0,  4,  4, 32'h55,       32'h55,        0, 0, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  4,  4, 32'h55,       32'h55,        1, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 4, 0,  4,  7, 32'h55,       32'h22,        1, 0, 1));

        // Reset state: count clear while held, every address reads zero and not pending.
        repeat (2) @(posedge clk);
        #1 chk("reset_cnt", 32'(busy_cnt_o), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 32; a += 2) begin
            ra_i = {5'(a + 1), 5'(a)};
            #1;
            chk("reset_rd0", rd_o[31:0], 0);
            chk("reset_rd1", rd_o[63:32], 0);
            chk("reset_busy", 32'(rd_busy_o), 0);
        end

        foreach (vecs[n]) begin
            @(negedge clk);
            we0_i = vecs[n].we0; wa0_i = vecs[n].wa0; wd0_i = vecs[n].wd0;
            we1_i = vecs[n].we1; wa1_i = vecs[n].wa1; wd1_i = vecs[n].wd1;
            issue_en_i = vecs[n].iss; issue_rd_i = vecs[n].ird; flush_i = vecs[n].fl;
            ra_i = {vecs[n].r1, vecs[n].r0};
            #1;
            chk($sformatf("vec%0d_rd0", n), rd_o[31:0], vecs[n].e0);
            chk($sformatf("vec%0d_rd1", n), rd_o[63:32], vecs[n].e1);
            chk($sformatf("vec%0d_busy0", n), 32'(rd_busy_o[0]), 32'(vecs[n].eb0));
            chk($sformatf("vec%0d_busy1", n), 32'(rd_busy_o[1]), 32'(vecs[n].eb1));
            @(posedge clk);
            model_edge();
            #1 chk($sformatf("vec%0d_cnt", n), 32'(busy_cnt_o), 32'(vecs[n].ecnt));
        end

        // Mid-cycle reset: state clears at once, same-cycle write/issue are discarded, bypass still drives rd.
        @(negedge clk);
        idle_inputs();
        we0_i = 1; wa0_i = 9; wd0_i = 32'h77;
        issue_en_i = 1; issue_rd_i = 9;
        ra_i = {5'd9, 5'd4};
        #1 chk("prerst_rd0", rd_o[31:0], 32'h55);
        rst = 1'b0;
        #1;
        chk("rst_cnt_now", 32'(busy_cnt_o), 0);
        chk("rst_rd0_clear", rd_o[31:0], 0);
        chk("rst_busy0", 32'(rd_busy_o[0]), 0);
        chk("rst_rd1_bypass", rd_o[63:32], 32'h77);
        @(posedge clk);
        #1 chk("rst_cnt_edge", 32'(busy_cnt_o), 0);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        model_reset();
        ra_i = {5'd5, 5'd9};
        #1;
        chk("postrst_rd9", rd_o[31:0], 0);
        chk("postrst_rd5", rd_o[63:32], 0);
        chk("postrst_busy", 32'(rd_busy_o), 0);
        @(posedge clk);
        #1 chk("postrst_cnt", 32'(busy_cnt_o), 0);

        // Randomized traffic against the reference model; narrow address range forces collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] r0, r1;
            @(negedge clk);
            we0_i = 1'($urandom_range(0, 1));
            we1_i = 1'($urandom_range(0, 1));
            issue_en_i = 1'($urandom_range(0, 1));
            flush_i = ($urandom_range(0, 15) == 0);
            wa0_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa1_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            issue_rd_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd0_i = $urandom;
            wd1_i = $urandom;
            r0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra_i = {r1, r0};
            #1;
            chk("rand_rd0", rd_o[31:0], exp_rd(r0));
            chk("rand_rd1", rd_o[63:32], exp_rd(r1));
            chk("rand_busy0", 32'(rd_busy_o[0]), 32'(exp_busy(r0)));
            chk("rand_busy1", 32'(rd_busy_o[1]), 32'(exp_busy(r1)));
            @(posedge clk);
            model_edge();
            #1 chk("rand_cnt", 32'(busy_cnt_o), 32'(model_cnt()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read, dual-write integer register file with write-to-read bypass, a hardwired zero register and a per-register busy scoreboard. It replaces the single-write, two-read register file in the datapath. The control FSM stalls on operands whose producer has issued but not yet written back.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0, is never written and is never marked busy
- AW (localparam), $clog2(NREGS)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ra  in  NRD×AW  read addresses, one per read port
- rd  out  NRD×XLEN  read data
- rd_busy  out  NRD  operand pending flag, one per read port
- we0, wa0, wd0  in  1, AW, XLEN  write port 0 (load/ALU writeback)
- we1, wa1, wd1  in  1, AW, XLEN  write port 1; has priority over port 0
- issue_en, issue_rd  in  1, AW  mark the destination register of an issuing instruction busy
- flush  in  1  clear all busy bits (branch redirect / exception)
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Storage: NREGS×XLEN array plus an NREGS-bit busy vector. Both are cleared asynchronously when rst=0.
- Write: at the posedge, reg[waN] ← wdN if weN, except waN=0 with ZERO_REG=1.
  - Both ports to the same address: port 1 value is stored.
- Read (combinational, per port i): the first matching rule supplies rd[i].
  1. ZERO_REG and ra[i]=0: rd[i]=0.
  2. we1 and wa1=ra[i]: rd[i]=wd1.
  3. we0 and wa0=ra[i]: rd[i]=wd0.
  4. Otherwise rd[i]=reg[ra[i]].
- Scoreboard, next-state of each bit in this order:
  1. Any enabled write port addressing register r clears busy[r].
  2. flush clears all bits.
  3. issue_en sets busy[issue_rd], unless issue_rd=0 with ZERO_REG.
  - Because issue is applied last, issue in the same cycle as a write or flush to the same register leaves busy=1 (the new producer wins).
- rd_busy[i] = busy[ra[i]] & ~(any enabled write to ra[i] this cycle). This is the bypass-consistent view. It is forced to 0 for ra[i]=0 with ZERO_REG.
- busy_cnt is a registered population count of the busy vector, updated each posedge from the next-state vector. Range 0..NREGS (or NREGS-1 with ZERO_REG).
- An issue to an already-busy register keeps it busy and does not change the count.

## Timing
- Read latency is 0 cycles: combinational from ra, the write ports and the state.
- Write and scoreboard latency is 1 cycle: visible in state after the posedge, and visible earlier on rd/rd_busy through the bypass.
- Reset values: all registers 0, busy 0, busy_cnt 0. During reset rd=0 for every address not being bypassed, and rd_busy=0.
- Reset asserted mid-operation: state clears immediately, and writes or issues presented that cycle are discarded.
- No handshakes. Every enable is a single-cycle qualifier, with no back-pressure.

## Structure
- Shared package regfile_pkg:
  - default XLEN/NREGS/NRD constants
  - an AW function wrapper
  - a write-port struct {we, wa, wd}, so that future write ports are added by array extension
- One sub-module, regfile_scoreboard. It holds the busy vector, the issue/write/flush priority logic, the popcount and busy_cnt, and returns busy for read-port lookup.
- Data array, bypass mux and zero-register gating stay in the top.

## Test plan
- Reset then read all addresses -> rd=0, rd_busy=0, busy_cnt=0.
- we0, wa0=5, wd0=0xDEAD_BEEF with ra[0]=5 in the same cycle -> rd[0]=0xDEADBEEF before the edge, and still after the edge with we0=0.
- we0 and we1 both target 7 (0x11, 0x22), ra[1]=7 -> rd[1]=0x22 that cycle, reg[7]=0x22 afterwards.
- Write 0x1234 to register 0, then issue_rd=0 -> rd=0, rd_busy=0, busy_cnt unchanged.
- issue_rd=3 -> busy_cnt=1, rd_busy=1 for ra=3. Next cycle we0 to 3 -> rd_busy=0 that cycle, busy_cnt=0 after the edge.
- Busy registers 3 and 4, then flush with issue_rd=4 in the same cycle -> only register 4 busy, busy_cnt=1. Asserting rst=0 mid-cycle -> busy_cnt=0 immediately.
